// File: rtl/restoring_div64x32.sv
// Iterative radix-2 restoring divider: 2W-bit unsigned dividend / W-bit divisor -> W-bit quotient + remainder.
// Latency: done pulses in the cycle after accept edge + W (normal) or after the accept edge (divide-by-zero / overflow).
// Backpressure: do_i is accepted only in IDLE; a request while busy is dropped and must be held or re-issued.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   dividend_i, divisor_i operands, sampled only on the accepting edge
//   do_i                 start request
//   quotient_o, remainder_o registered results, held until the next completion
//   busy_o               high while iterating
//   done_o               single-cycle completion pulse
//   div_by_zero_o, overflow_o result flags, valid with done_o and held likewise
module restoring_div64x32 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*W-1:0] dividend_i,
    input  logic [W-1:0]   divisor_i,
    input  logic           do_i,
    output logic [W-1:0]   quotient_o,
    output logic [W-1:0]   remainder_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           div_by_zero_o,
    output logic           overflow_o
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    // Partial remainder. The W+1-th bit of R is always zero because R<D
    // holds after every step, so only W bits are stored.
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    // One restoring step: shift the next dividend bit into R and try a subtract.
    logic [W:0]     trial;
    logic           qbit;
    logic [W-1:0]   r_step;
    logic [W-1:0]   q_step;

    always_comb begin
        trial = {r_q, q_q[W-1]};
        qbit  = (trial >= {1'b0, d_q});
        // When the subtract succeeds the difference is < D, so its low W bits are exact.
        r_step = qbit ? (trial[W-1:0] - d_q) : trial[W-1:0];
        q_step = {q_q[W-2:0], qbit};
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (do_i) begin
                    d_d = divisor_i;
                    if (divisor_i == '0) begin
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        quotient_d  = '1;
                        remainder_d = dividend_i[W-1:0];
                    end else if (dividend_i[2*W-1:W] >= divisor_i) begin
                        // Quotient would need more than W bits.
                        done_d      = 1'b1;
                        ovf_d       = 1'b1;
                        dbz_d       = 1'b0;
                        quotient_d  = '1;
                        remainder_d = '0;
                    end else begin
                        r_d     = dividend_i[2*W-1:W];
                        q_d     = dividend_i[W-1:0];
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    quotient_d  = q_step;
                    remainder_d = r_step;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign busy_o        = (state_q == RUN);
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;

endmodule
